serv_seqctl: RTL and testbench

SERV_SEQCTL -- requirements
Module: serv_seqctl

---
 rtl/serv_seqctl.sv | 178 +++++++++++++++++
 tb/tb_serv_seqctl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_seqctl.sv
// Bit-serial instruction sequencer: fetch, RF request, optional INIT/MEM stages, RUN.
// Optional trap support is compiled in with `define SERV_SEQCTL_TRAP_EN.
module serv_seqctl #(
  parameter int W              = 1,
  parameter     RESET_STRATEGY = "MINI"
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ibus_ack,
  input  logic       i_dbus_ack,
  input  logic       i_rf_ready,
  input  logic       i_stall,
  input  logic       i_two_stage_op,
  input  logic       i_branch_op,
  input  logic       i_cond_branch,
  input  logic       i_bne_or_bge,
  input  logic       i_alu_cmp,
  input  logic       i_dbus_en,
  input  logic       i_mem_misalign,
  input  logic       i_ctrl_misalign,
  output logic       o_ibus_cyc,
  output logic       o_dbus_cyc,
  output logic       o_rf_rreq,
  output logic       o_rf_wreq,
  output logic [4:0] o_cnt,
  output logic       o_cnt_en,
  output logic       o_cnt_done,
  output logic       o_init,
  output logic       o_ctrl_pc_en,
  output logic       o_ctrl_jump,
  output logic       o_ctrl_trap,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_RDREQ = 3'd1,
    ST_INIT  = 3'd2,
    ST_MEM   = 3'd3,
    ST_RUN   = 3'd4
  } state_e;

  localparam logic [4:0] CNT_STEP = 5'(W);
  localparam logic [4:0] CNT_LAST = 5'(32 - W);

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       jump_q, jump_d;
  logic       init_done_q, init_done_d;
  logic       rf_rreq_q, rf_rreq_d;
  logic       rf_wreq_q, rf_wreq_d;
  logic       cnt_en, cnt_done, take_branch, trap_pending;

  assign cnt_en      = (state_q == ST_INIT) || (state_q == ST_RUN);
  assign cnt_done    = cnt_en && (cnt_q == CNT_LAST) && !i_stall;
  assign take_branch = i_branch_op & (!i_cond_branch | (i_alu_cmp ^ i_bne_or_bge));

`ifdef SERV_SEQCTL_TRAP_EN
  logic trap_q, trap_d;

  assign trap_pending = (take_branch & i_ctrl_misalign) | (i_dbus_en & i_mem_misalign);
  assign o_ctrl_trap  = trap_q;

  always_comb begin
    trap_d = trap_q;
    if (state_q == ST_INIT && cnt_done)     trap_d = trap_pending;
    else if (state_q == ST_RUN && cnt_done) trap_d = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) trap_q <= 1'b0;
    else          trap_q <= trap_d;
  end
`else
  logic unused_misalign;

  assign unused_misalign = i_mem_misalign | i_ctrl_misalign;
  assign trap_pending    = 1'b0;
  assign o_ctrl_trap     = 1'b0;
`endif

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    rf_rreq_d   = 1'b0;
    rf_wreq_d   = 1'b0;
    init_done_d = init_done_q;
    jump_d      = jump_q;

    unique case (state_q)
      ST_FETCH: begin
        if (i_ibus_ack) begin
          state_d   = ST_RDREQ;
          rf_rreq_d = 1'b1;
        end
      end
      ST_RDREQ: begin
        // The second visit after INIT always proceeds to RUN.
        if (i_rf_ready) state_d = (i_two_stage_op && !init_done_q) ? ST_INIT : ST_RUN;
      end
      ST_INIT: begin
        if (cnt_done) begin
          init_done_d = 1'b1;
          jump_d      = take_branch;
          if (i_dbus_en && !trap_pending) begin
            state_d = ST_MEM;
          end else begin
            state_d   = ST_RDREQ;
            rf_wreq_d = !trap_pending;
            rf_rreq_d = trap_pending;
          end
        end
      end
      ST_MEM: begin
        if (i_dbus_ack) state_d = ST_RDREQ;
      end
      ST_RUN: begin
        if (cnt_done) begin
          state_d     = ST_FETCH;
          init_done_d = 1'b0;
          jump_d      = 1'b0;
        end
      end
      default: state_d = ST_FETCH;
    endcase

    if (!cnt_en)       cnt_d = 5'd0;
    else if (i_stall)  cnt_d = cnt_q;
    else               cnt_d = cnt_q + CNT_STEP;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_FETCH;
      rf_rreq_q   <= 1'b0;
      rf_wreq_q   <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rf_rreq_q   <= rf_rreq_d;
      rf_wreq_q   <= rf_wreq_d;
      init_done_q <= init_done_d;
    end
  end

  if (RESET_STRATEGY == "NONE") begin : g_cnt_noreset
    // NOTE: these flops are deliberately unreset; the counter self-clears whenever no stage is active.
    always_ff @(posedge i_clk) begin
      cnt_q  <= cnt_d;
      jump_q <= jump_d;
    end
  end else begin : g_cnt_reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        cnt_q  <= 5'd0;
        jump_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        jump_q <= jump_d;
      end
    end
  end

  // Gated by reset so no fetch is requested while held in reset.
  assign o_ibus_cyc   = (state_q == ST_FETCH) && i_rst_n;
  assign o_dbus_cyc   = (state_q == ST_MEM);
  assign o_rf_rreq    = rf_rreq_q;
  assign o_rf_wreq    = rf_wreq_q | ((state_q == ST_MEM) && i_dbus_ack);
  assign o_cnt        = cnt_q;
  assign o_cnt_en     = cnt_en;
  assign o_cnt_done   = cnt_done;
  assign o_init       = (state_q == ST_INIT);
  assign o_ctrl_pc_en = cnt_en && (state_q == ST_RUN) && !i_stall;
  assign o_ctrl_jump  = jump_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_serv_seqctl.sv
// Directed bench for serv_seqctl: four instances (W=1,2,4,8), each driven by its own input set.
module tb_serv_seqctl;

  localparam logic [2:0] ST_FETCH = 3'd0;
  localparam logic [2:0] ST_RDREQ = 3'd1;
  localparam logic [2:0] ST_INIT  = 3'd2;
  localparam logic [2:0] ST_MEM   = 3'd3;
  localparam logic [2:0] ST_RUN   = 3'd4;

  logic clk;
  logic rst_n;

  logic [3:0] ibus_ack, dbus_ack, rf_ready, stall;
  logic [3:0] two_stage, branch_op, cond_branch, bne_or_bge, alu_cmp, dbus_en;
  logic [3:0] mem_mis, ctrl_mis;

  logic       ibus_cyc_o [4];
  logic       dbus_cyc_o [4];
  logic       rf_rreq_o  [4];
  logic       rf_wreq_o  [4];
  logic [4:0] cnt_o      [4];
  logic       cnt_en_o   [4];
  logic       cnt_done_o [4];
  logic       init_o     [4];
  logic       pc_en_o    [4];
  logic       jump_o     [4];
  logic       trap_o     [4];
  logic [2:0] state_o    [4];

  int n_vec = 0;
  int n_err = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    serv_seqctl #(.W(1 << g)) u_dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_ibus_ack     (ibus_ack[g]),
      .i_dbus_ack     (dbus_ack[g]),
      .i_rf_ready     (rf_ready[g]),
      .i_stall        (stall[g]),
      .i_two_stage_op (two_stage[g]),
      .i_branch_op    (branch_op[g]),
      .i_cond_branch  (cond_branch[g]),
      .i_bne_or_bge   (bne_or_bge[g]),
      .i_alu_cmp      (alu_cmp[g]),
      .i_dbus_en      (dbus_en[g]),
      .i_mem_misalign (mem_mis[g]),
      .i_ctrl_misalign(ctrl_mis[g]),
      .o_ibus_cyc     (ibus_cyc_o[g]),
      .o_dbus_cyc     (dbus_cyc_o[g]),
      .o_rf_rreq      (rf_rreq_o[g]),
      .o_rf_wreq      (rf_wreq_o[g]),
      .o_cnt          (cnt_o[g]),
      .o_cnt_en       (cnt_en_o[g]),
      .o_cnt_done     (cnt_done_o[g]),
      .o_init         (init_o[g]),
      .o_ctrl_pc_en   (pc_en_o[g]),
      .o_ctrl_jump    (jump_o[g]),
      .o_ctrl_trap    (trap_o[g]),
      .o_state        (state_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected the run to finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rst_view(input int k);
    return {15'd0, state_o[k], cnt_o[k], cnt_en_o[k], jump_o[k], trap_o[k], rf_rreq_o[k],
            rf_wreq_o[k], dbus_cyc_o[k], ibus_cyc_o[k]};
  endfunction

  task automatic clear_inputs(input int k);
    ibus_ack[k] = 0; dbus_ack[k] = 0; rf_ready[k] = 0; stall[k] = 0;
    two_stage[k] = 0; branch_op[k] = 0; cond_branch[k] = 0; bne_or_bge[k] = 0;
    alu_cmp[k] = 0; dbus_en[k] = 0; mem_mis[k] = 0; ctrl_mis[k] = 0;
  endtask

  task automatic do_fetch(input int k);
    check("fetch_req", {state_o[k], ibus_cyc_o[k]}, {ST_FETCH, 1'b1});
    ibus_ack[k] = 1'b1;
    step();
    ibus_ack[k] = 1'b0;
    check("fetch_rreq", {state_o[k], rf_rreq_o[k], ibus_cyc_o[k]}, {ST_RDREQ, 1'b1, 1'b0});
  endtask

  task automatic do_rdreq(input int k, input logic exp_rreq, input logic exp_wreq,
                          input logic [2:0] exp_next);
    #1;
    check("rdreq", {state_o[k], rf_rreq_o[k], rf_wreq_o[k]}, {ST_RDREQ, exp_rreq, exp_wreq});
    rf_ready[k] = 1'b1;
    step();
    rf_ready[k] = 1'b0;
    check("rdreq_next", {state_o[k], rf_rreq_o[k], cnt_o[k], cnt_en_o[k]},
          {exp_next, 1'b0, 5'd0, 1'b1});
  endtask

  // One full unstalled stage: 32/w cycles, counter stepping by w, done on the last beat.
  task automatic do_stage(input int k, input int w, input logic is_run, input logic exp_jump,
                          input logic exp_trap);
    int n;
    n = 32 / w;
    for (int i = 0; i < n; i++) begin
      check($sformatf("stage_w%0d_i%0d", w, i),
            {cnt_o[k], cnt_en_o[k], cnt_done_o[k], pc_en_o[k], init_o[k], jump_o[k], trap_o[k]},
            {5'(i * w), 1'b1, (i == n - 1), is_run, !is_run, exp_jump, exp_trap});
      step();
    end
  endtask

  // Two-stage branch; the ALU compare flips after INIT to show the decision is latched.
  task automatic run_branch(input int k, input int w, input logic cond, input logic cmp,
                            input logic bne, input logic exp_jump);
    two_stage[k] = 1; branch_op[k] = 1; cond_branch[k] = cond;
    alu_cmp[k] = cmp; bne_or_bge[k] = bne; dbus_en[k] = 0;
    do_fetch(k);
    do_rdreq(k, 1'b1, 1'b0, ST_INIT);
    do_stage(k, w, 1'b0, 1'b0, 1'b0);
    alu_cmp[k] = !cmp;
    do_rdreq(k, 1'b0, 1'b1, ST_RUN);
    do_stage(k, w, 1'b1, exp_jump, 1'b0);
    check("branch_end", {state_o[k], jump_o[k], ibus_cyc_o[k]}, {ST_FETCH, 1'b0, 1'b1});
    clear_inputs(k);
  endtask

  int d_stall [6] = '{0, 1, 1, 0, 0, 0};
  int d_cnt   [6] = '{0, 8, 8, 8, 16, 24};

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) clear_inputs(k);

    // Held in reset: everything idle, no fetch request.
    #2;
    for (int k = 0; k < 4; k++) check($sformatf("reset_%0d", k), rst_view(k), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 4; k++)
      check($sformatf("release_%0d", k), {state_o[k], ibus_cyc_o[k]}, {ST_FETCH, 1'b1});

    // W=1 ALU op; stray rf_ready in FETCH and ibus_ack in RDREQ must be ignored.
    rf_ready[0] = 1'b1;
    step();
    rf_ready[0] = 1'b0;
    check("rf_ready_in_fetch", {29'd0, state_o[0]}, {29'd0, ST_FETCH});
    do_fetch(0);
    ibus_ack[0] = 1'b1;
    do_rdreq(0, 1'b1, 1'b0, ST_RUN);
    ibus_ack[0] = 1'b0;
    do_stage(0, 1, 1'b1, 1'b0, 1'b0);
    check("alu_end", {state_o[0], ibus_cyc_o[0], cnt_en_o[0], cnt_o[0]},
          {ST_FETCH, 1'b1, 1'b0, 5'd0});

    // W=4 taken beq.
    run_branch(2, 4, 1'b1, 1'b1, 1'b0, 1'b1);

    // W=2 load with 3-cycle data latency; stray dbus_ack in RDREQ must not pulse rf_wreq.
    two_stage[1] = 1; dbus_en[1] = 1;
`ifndef SERV_SEQCTL_TRAP_EN
    mem_mis[1] = 1;
`endif
    do_fetch(1);
    dbus_ack[1] = 1'b1;
    do_rdreq(1, 1'b1, 1'b0, ST_INIT);
    dbus_ack[1] = 1'b0;
    do_stage(1, 2, 1'b0, 1'b0, 1'b0);
    for (int m = 0; m < 3; m++) begin
      dbus_ack[1] = (m == 2);
      #1;
      check($sformatf("mem_%0d", m), {state_o[1], dbus_cyc_o[1], rf_wreq_o[1], cnt_en_o[1]},
            {ST_MEM, 1'b1, (m == 2), 1'b0});
      step();
    end
    dbus_ack[1] = 1'b0;
    do_rdreq(1, 1'b0, 1'b0, ST_RUN);
    do_stage(1, 2, 1'b1, 1'b0, 1'b0);
    check("load_end", {state_o[1], dbus_cyc_o[1], ibus_cyc_o[1]}, {ST_FETCH, 1'b0, 1'b1});
    clear_inputs(1);

    // W=8 ALU op stalled two cycles at cnt=8; stall during FETCH has no effect.
    stall[3] = 1'b1;
    do_fetch(3);
    stall[3] = 1'b0;
    do_rdreq(3, 1'b1, 1'b0, ST_RUN);
    for (int i = 0; i < 6; i++) begin
      stall[3] = (d_stall[i] != 0);
      #1;
      check($sformatf("stall_%0d", i), {state_o[3], cnt_o[3], pc_en_o[3], cnt_done_o[3]},
            {ST_RUN, 5'(d_cnt[i]), (d_stall[i] == 0), (i == 5)});
      step();
    end
    stall[3] = 1'b0;
    check("stall_end", {29'd0, state_o[3]}, {29'd0, ST_FETCH});

    // Branch decode variants: bne equal (not taken), jal, bge taken.
    run_branch(3, 8, 1'b1, 1'b1, 1'b1, 1'b0);
    run_branch(3, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    run_branch(1, 2, 1'b1, 1'b0, 1'b1, 1'b1);

`ifdef SERV_SEQCTL_TRAP_EN
    // Misaligned load: MEM skipped, read request after INIT, trap for the whole RUN.
    two_stage[1] = 1; dbus_en[1] = 1; mem_mis[1] = 1;
    do_fetch(1);
    do_rdreq(1, 1'b1, 1'b0, ST_INIT);
    do_stage(1, 2, 1'b0, 1'b0, 1'b0);
    check("trap_skip_mem", {state_o[1], dbus_cyc_o[1]}, {ST_RDREQ, 1'b0});
    do_rdreq(1, 1'b1, 1'b0, ST_RUN);
    do_stage(1, 2, 1'b1, 1'b0, 1'b1);
    check("trap_end", {state_o[1], trap_o[1]}, {ST_FETCH, 1'b0});
    clear_inputs(1);
`endif

    // W=1 jal interrupted by reset at cnt=12 in RUN.
    two_stage[0] = 1; branch_op[0] = 1;
    do_fetch(0);
    do_rdreq(0, 1'b1, 1'b0, ST_INIT);
    do_stage(0, 1, 1'b0, 1'b0, 1'b0);
    do_rdreq(0, 1'b0, 1'b1, ST_RUN);
    repeat (12) step();
    check("pre_reset", {cnt_o[0], jump_o[0], state_o[0]}, {5'd12, 1'b1, ST_RUN});
    rst_n = 1'b0;
    #1;
    check("reset_async", rst_view(0), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("reset_release", {state_o[0], ibus_cyc_o[0]}, {ST_FETCH, 1'b1});
    do_fetch(0);
    do_rdreq(0, 1'b1, 1'b0, ST_INIT);
    clear_inputs(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
